// File: rtl/usr_pkg.sv
// Shared types and constants for the serial frame receiver.
// Optional parity support is selected with USR_RX_PARITY_EN.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DEF_DATA_W = 8;

endpackage

// File: rtl/usr_out_buf.sv
// One-entry valid/ready holding register for received words.
// A word arriving while the entry is full and not draining is dropped.
module usr_out_buf
  import usr_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         acc,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic [W-1:0] dout,
  output logic         vld,
  output logic         ovr
);

  // Load on accept when the slot is free or draining; else flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      vld  <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (acc) begin
        if (vld && !rdy) begin
          ovr <= 1'b1;
        end else begin
          dout <= din;
          vld  <= 1'b1;
        end
      end else if (vld && rdy) begin
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/usr_frame_rx.sv
// Serial frame receiver fed by the shift register serial output.
// Define USR_RX_PARITY_EN to add an even parity bit before the stop bit.
module usr_frame_rx
  import usr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdi,
  input  logic              sdi_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] pdata,
  output logic              pdata_vld,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovr_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sreg;
  logic              acc;

`ifdef USR_RX_PARITY_EN
  logic              par_mis;
`endif

  assign busy = (state != IDLE);

`ifdef USR_RX_PARITY_EN
  assign acc = sdi_vld && (state == STOP)
            && (sdi == STOP_BIT) && !par_mis;
`else
  assign acc = sdi_vld && (state == STOP)
            && (sdi == STOP_BIT);
`endif

  // Frame FSM: advances one step per bit strobe, LSB-first shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg    <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
`ifdef USR_RX_PARITY_EN
      par_mis <= 1'b0;
`endif
    end else begin
      par_err <= 1'b0;
      frm_err <= 1'b0;
      if (sdi_vld) begin
        unique case (state)
          IDLE: begin
            if (sdi == START_BIT) begin
              state <= DATA;
              cnt   <= '0;
`ifdef USR_RX_PARITY_EN
              par_mis <= 1'b0;
`endif
            end
          end
          DATA: begin
            sreg <= {sdi, sreg[DATA_W-1:1]};
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
`ifdef USR_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef USR_RX_PARITY_EN
          PARITY: begin
            par_mis <= (^sreg) ^ sdi;
            state   <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
            if (sdi != STOP_BIT) begin
              frm_err <= 1'b1;
            end
`ifdef USR_RX_PARITY_EN
            else if (par_mis) begin
              par_err <= 1'b1;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  usr_out_buf #(
    .W(DATA_W)
  ) u_buf (
    .clk (clk),
    .rst (rst),
    .acc (acc),
    .din (sreg),
    .rdy (out_rdy),
    .dout(pdata),
    .vld (pdata_vld),
    .ovr (ovr_err)
  );

endmodule

// File: doc/usr_frame_rx.md
Name: usr_frame_rx

Overview:
- Serial frame receiver directly downstream of the 4-bit universal shift register; consumes its serial-out bit stream (srdo/sldo), one bit per strobe.
- Detects start bit, assembles LSB-first data word, optionally checks even parity, checks stop bit.
- Presents the word on a one-entry valid/ready output buffer to the next stage.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..16)
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > DATA_W

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- sdi  in  1  serial data bit from shift-register serial output
- sdi_vld  in  1  bit strobe; sdi is sampled only when high
- out_rdy  in  1  downstream ready
- pdata  out  DATA_W  received word, bit 0 = first data bit received
- pdata_vld  out  1  pdata holds an unconsumed word
- par_err  out  1  one-cycle pulse, parity mismatch
- frm_err  out  1  one-cycle pulse, stop bit sampled 0
- ovr_err  out  1  one-cycle pulse, completed frame dropped because buffer full
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE; bit counter=0; shift reg=0; pdata=0; pdata_vld=0; par_err=frm_err=ovr_err=0; busy=0.
- Reset mid-frame abandons the frame at that edge. No error pulse. Buffered word is discarded.
- FSM advances only on cycles with sdi_vld=1. Otherwise state and shift reg hold.
- IDLE: sdi_vld & sdi==0 (start bit) -> DATA, counter=0. sdi==1 is line idle; stay.
- DATA: each strobe shifts sdi into the MSB of the shift reg (right shift) and increments the counter.
  - On the strobe with counter==DATA_W-1 -> PARITY if parity is compiled in, else STOP.
- PARITY: the strobe samples the parity bit -> STOP. Records mismatch flag = (^shift_reg) ^ sdi (even parity).
- STOP: the strobe samples the stop bit -> IDLE in all cases.
  - sdi==0: frm_err pulses in the next cycle. Word is discarded; par_err is suppressed.
  - sdi==1 and parity mismatch: par_err pulses. Word is discarded.
  - sdi==1 and no mismatch: word is accepted.
- Accept: registered at the clock edge of the stop-bit strobe. pdata/pdata_vld are updated at that edge, so latency is 1 cycle from the stop strobe.
- Handshake: transfer occurs when pdata_vld & out_rdy. pdata_vld then clears unless a new word is accepted at the same edge. pdata is stable while pdata_vld=1 and out_rdy=0.
- Simultaneous accept and transfer (out_rdy=1 at the stop-strobe edge): the old word is consumed and the new word loaded. pdata_vld stays 1. No overrun.
- Buffer full at accept (pdata_vld=1, out_rdy=0): the new word is dropped, ovr_err pulses, and the old word is retained.
- Back-to-back frames: a start bit may arrive on the strobe immediately after the stop strobe.
- Error pulses are mutually exclusive and last exactly one cycle.

Optional Feature:
- Macro: USR_RX_PARITY_EN.
- Defined: frame = start + DATA_W data + even parity + stop; the PARITY state exists; par_err is active.
- Undefined: frame = start + DATA_W data + stop; the PARITY state is removed; par_err is tied to 0.

Decomposition:
- Shared package usr_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), constants START_BIT=0, STOP_BIT=1, default DATA_W.
- One sub-module: usr_out_buf, the one-entry valid/ready holding register with overrun detect. The FSM and shift logic stay in the top.

Test Plan:
- Parity on, DATA_W=8, out_rdy=1: strobe start 0, data 0xA5 LSB-first, parity 0, stop 1 -> pdata=0xA5, pdata_vld high 1 cycle after the stop strobe, no error pulses.
- Parity on: send 0x3C with parity bit 1 -> par_err pulses once; pdata_vld stays 0; next valid frame 0x01 is received correctly.
- Send 0x55 with stop bit 0 -> frm_err pulses once; pdata_vld stays 0; FSM returns to IDLE (busy=0).
- out_rdy=0: send 0x11 then 0x22 -> pdata=0x11 held, ovr_err pulses at the second stop; raise out_rdy -> 0x11 transfers, pdata_vld=0.
- Strobes with 3 idle cycles between each bit; assert rst after 4 data bits -> all outputs 0 next cycle. Then a full frame 0xF0 is received correctly.
- out_rdy=1 and two back-to-back frames 0x81, 0x7E with the start bit on the strobe right after the stop -> two consecutive words, no ovr_err.
